// File: rtl/ltl_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ltl_mon_pkg
// Description : Shared constants and event record type for the cluster-1 LTL
//               monitor consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package ltl_mon_pkg;

    localparam int NUM_PROPS  = 9;
    localparam int TS_WIDTH   = 16;
    localparam int CNT_WIDTH  = 8;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [TS_WIDTH-1:0]  ts;
        logic [NUM_PROPS-1:0] mask;
    } ltl_evt_t;

    localparam int LTL0 = 0;
    localparam int LTL1 = 1;
    localparam int LTL2 = 2;
    localparam int LTL3 = 3;
    localparam int LTL4 = 4;
    localparam int LTL5 = 5;
    localparam int LTL6 = 6;
    localparam int LTL7 = 7;
    localparam int LTL8 = 8;

endpackage
`default_nettype wire

// File: rtl/ltl_event_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : ltl_event_collector_if
// Description : Valid/ready event stream from the collector to its sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface ltl_event_collector_if
    import ltl_mon_pkg::*;
#(
    parameter int DATA_WIDTH = TS_WIDTH + NUM_PROPS
);
    logic                  evt_valid;
    logic                  evt_ready;
    logic [DATA_WIDTH-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/ltl_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ltl_evt_fifo
// Description : Synchronous event FIFO with a registered head (valid + data);
//               the head is preloaded from the next-state read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module ltl_evt_fifo #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_push,
    input  wire logic [DATA_WIDTH-1:0] i_push_data,
    input  wire logic                  i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_head_valid,
    output logic [DATA_WIDTH-1:0]      o_head_data
);
    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]         r_wr_ptr;
    logic [c_AW:0]         r_rd_ptr;
    logic [c_AW:0]         w_wr_ptr_nxt;
    logic [c_AW:0]         w_rd_ptr_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_valid;

    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign w_wr_ptr_nxt = r_wr_ptr + (c_AW+1)'(w_do_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (c_AW+1)'(w_do_pop);

    // Bypass when the entry being written is the one that becomes the head.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[c_AW-1:0]];
        if (w_do_push && (w_rd_ptr_nxt[c_AW-1:0] == r_wr_ptr[c_AW-1:0])) begin
            w_head_nxt = i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_head_valid <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
            r_head_data  <= w_head_nxt;
        end
    end

    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;

endmodule
`default_nettype wire

// File: rtl/ltl_event_collector.sv
`default_nettype none
// ============================================================================
// Module      : ltl_event_collector
// Description : Registers LTL hit flags, keeps sticky status and saturating
//               hit counters, and queues time-stamped hit events.
// Revision    : 1.0 - initial release
// ============================================================================
module ltl_event_collector #(
    parameter int NUM_PROPS  = ltl_mon_pkg::NUM_PROPS,
    parameter int TS_WIDTH   = ltl_mon_pkg::TS_WIDTH,
    parameter int CNT_WIDTH  = ltl_mon_pkg::CNT_WIDTH,
    parameter int FIFO_DEPTH = ltl_mon_pkg::FIFO_DEPTH
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic                           run,
    input  wire logic [NUM_PROPS-1:0]           ltl_hits,
    input  wire logic                           clear_sticky,
    ltl_event_collector_if.master               evt,
    output logic [NUM_PROPS-1:0]                sticky,
    output logic [NUM_PROPS*CNT_WIDTH-1:0]      hit_count,
    output logic                                overflow,
    output logic                                irq
);
    import ltl_mon_pkg::*;

    localparam int c_EVT_W = TS_WIDTH + NUM_PROPS;

    logic [TS_WIDTH-1:0]  r_ts;
    logic [TS_WIDTH-1:0]  r_ts_q;
    logic [NUM_PROPS-1:0] r_hits_q;
    logic [NUM_PROPS-1:0] r_sticky;
    logic                 r_overflow;
    logic                 r_irq;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_EVT_W-1:0]   w_push_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts     <= '0;
            r_ts_q   <= '0;
            r_hits_q <= '0;
        end else begin
            r_hits_q <= run ? ltl_hits : '0;
            r_ts_q   <= r_ts;
            if (run) begin
                r_ts <= r_ts + TS_WIDTH'(1);
            end
        end
    end

    assign w_push      = |r_hits_q;
    assign w_pop       = evt.evt_ready && !w_fifo_empty;
    assign w_drop      = w_push && w_fifo_full && !w_pop;
    assign w_push_data = {r_ts_q, r_hits_q};

    ltl_evt_fifo #(
        .DATA_WIDTH (c_EVT_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_head_valid (evt.evt_valid),
        .o_head_data  (evt.evt_data)
    );

    // A hit arriving together with clear_sticky survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky   <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sticky   <= (clear_sticky ? '0 : r_sticky) | r_hits_q;
            r_overflow <= (clear_sticky ? 1'b0 : r_overflow) | w_drop;
            r_irq      <= |r_sticky;
        end
    end

    for (genvar gi = 0; gi < NUM_PROPS; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (r_hits_q[gi]) begin
                if (clear_sticky) begin
                    r_cnt <= CNT_WIDTH'(1);
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end else if (clear_sticky) begin
                r_cnt <= '0;
            end
        end

        assign hit_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end

    assign sticky   = r_sticky;
    assign overflow = r_overflow;
    assign irq      = r_irq;

endmodule
`default_nettype wire
